// File: rtl/cell_test_pkg.sv
// Shared types and constants for the cell characterization sequencer.
package cell_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        FIN
    } t_cts_state;

    localparam int MAX_INPUTS = 4;
    localparam int MAX_VEC    = 16;
    localparam int ERR_W      = 5;

    function automatic logic [2:0] clamp_inputs(input logic [2:0] n);
        return (n > 3'(MAX_INPUTS)) ? 3'(MAX_INPUTS) : n;
    endfunction

endpackage

// File: rtl/cell_test_settle_timer.sv
// Loadable down-counter timing the settle window of each vector.
module cell_test_settle_timer #(
    parameter int W        = 2,
    parameter int LOAD_VAL = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic tick,
    output logic expire
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = W'(LOAD_VAL);
        end else if (tick && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Expire marks the last settle cycle so SAMPLE follows directly.
    assign expire = (cnt_q <= W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cell_test_sequencer.sv
// Exhaustive truth-table sequencer for cells sharing one stimulus bus.
// CELL_TEST_FAILMAP_EN adds the per-vector FAIL_MAP output.
module cell_test_sequencer
    import cell_test_pkg::*;
#(
    parameter int NUM_CUT       = 8,
    parameter int SEL_W         = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    input  logic [SEL_W-1:0]   CUT_SEL,
    input  logic [2:0]         N_INPUTS,
    input  logic [15:0]        EXP_TT,
    input  logic [NUM_CUT-1:0] OBS,
    output logic [3:0]         STIM,
    output logic [NUM_CUT-1:0] CUT_EN,
    output logic               BUSY,
    output logic               DONE,
    output logic               PASS,
    output logic               BAD_SEL,
    output logic [ERR_W-1:0]   ERR_CNT,
    output logic [3:0]         FIRST_FAIL
`ifdef CELL_TEST_FAILMAP_EN
    ,
    output logic [MAX_VEC-1:0] FAIL_MAP
`endif
);

    localparam int TW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    t_cts_state         state_q, state_d;
    logic [3:0]         vec_q, vec_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [2:0]         n_q, n_d;
    logic [15:0]        exp_q, exp_d;
    logic [3:0]         stim_q, stim_d;
    logic [NUM_CUT-1:0] cut_en_q, cut_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               bad_q, bad_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [3:0]         ff_q, ff_d;
`ifdef CELL_TEST_FAILMAP_EN
    logic [MAX_VEC-1:0] fmap_q, fmap_d;
`endif

    logic               tmr_load, tmr_tick, tmr_expire;
    logic [NUM_CUT-1:0] start_onehot;
    logic               obs_bit;
    logic [3:0]         last_vec;

    cell_test_settle_timer #(
        .W        (TW),
        .LOAD_VAL (SETTLE_CYCLES)
    ) u_timer (
        .clk    (CLK),
        .rst_n  (RST_N),
        .load   (tmr_load),
        .tick   (tmr_tick),
        .expire (tmr_expire)
    );

    always_comb begin
        start_onehot = '0;
        obs_bit      = 1'b0;
        for (int i = 0; i < NUM_CUT; i++) begin
            if (CUT_SEL == SEL_W'(i)) start_onehot[i] = 1'b1;
            if (sel_q == SEL_W'(i)) obs_bit = OBS[i];
        end
    end

    // Last vector is 2^n - 1, which also serves as the stimulus mask.
    assign last_vec = 4'((5'd1 << n_q) - 5'd1);

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        sel_d    = sel_q;
        n_d      = n_q;
        exp_d    = exp_q;
        stim_d   = stim_q;
        cut_en_d = cut_en_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        bad_d    = bad_q;
        err_d    = err_q;
        ff_d     = ff_q;
`ifdef CELL_TEST_FAILMAP_EN
        fmap_d   = fmap_q;
`endif
        tmr_load = 1'b0;
        tmr_tick = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    sel_d  = CUT_SEL;
                    n_d    = clamp_inputs(N_INPUTS);
                    exp_d  = EXP_TT;
                    err_d  = '0;
                    ff_d   = '0;
                    pass_d = 1'b0;
                    vec_d  = '0;
`ifdef CELL_TEST_FAILMAP_EN
                    fmap_d = '0;
`endif
                    if (32'(CUT_SEL) >= NUM_CUT) begin
                        bad_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        bad_d    = 1'b0;
                        stim_d   = '0;
                        cut_en_d = start_onehot;
                        busy_d   = 1'b1;
                        state_d  = APPLY;
                    end
                end
            end
            APPLY: begin
                tmr_load = 1'b1;
                state_d  = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
            end
            SETTLE: begin
                tmr_tick = 1'b1;
                if (tmr_expire) state_d = SAMPLE;
            end
            SAMPLE: begin
                if (obs_bit != exp_q[vec_q]) begin
                    err_d = err_q + ERR_W'(1);
                    if (err_q == '0) ff_d = vec_q;
`ifdef CELL_TEST_FAILMAP_EN
                    fmap_d[vec_q] = 1'b1;
`endif
                end
                if (vec_q == last_vec) begin
                    state_d  = FIN;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    cut_en_d = '0;
                    stim_d   = '0;
                    pass_d   = (err_d == '0) && !bad_q;
                end else begin
                    vec_d   = vec_q + 4'd1;
                    stim_d  = (vec_q + 4'd1) & last_vec;
                    state_d = APPLY;
                end
            end
            FIN: begin
                // A rejected select enters FIN without DONE; pulse it here.
                if (done_q) begin
                    state_d = IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            sel_q    <= '0;
            n_q      <= '0;
            exp_q    <= '0;
            stim_q   <= '0;
            cut_en_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            bad_q    <= 1'b0;
            err_q    <= '0;
            ff_q     <= '0;
`ifdef CELL_TEST_FAILMAP_EN
            fmap_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            sel_q    <= sel_d;
            n_q      <= n_d;
            exp_q    <= exp_d;
            stim_q   <= stim_d;
            cut_en_q <= cut_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            bad_q    <= bad_d;
            err_q    <= err_d;
            ff_q     <= ff_d;
`ifdef CELL_TEST_FAILMAP_EN
            fmap_q   <= fmap_d;
`endif
        end
    end

    assign STIM       = stim_q;
    assign CUT_EN     = cut_en_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign PASS       = pass_q;
    assign BAD_SEL    = bad_q;
    assign ERR_CNT    = err_q;
    assign FIRST_FAIL = ff_q;
`ifdef CELL_TEST_FAILMAP_EN
    assign FAIL_MAP   = fmap_q;
`endif

endmodule
